// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the core/debug requesters, the data RAM arbiter and the RAM macro.
// The arbiter takes the slave view; the requesters and RAM together take the master view.
interface data_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  core_req_i;
    logic                  core_we_i;
    logic [ADDR_WIDTH-1:0] core_addr_i;
    logic [BE_WIDTH-1:0]   core_be_i;
    logic [DATA_WIDTH-1:0] core_wdata_i;
    logic                  core_gnt_o;
    logic                  core_stall_o;
    logic                  core_rvalid_o;
    logic [DATA_WIDTH-1:0] core_rdata_o;

    logic                  dbg_req_i;
    logic                  dbg_we_i;
    logic [ADDR_WIDTH-1:0] dbg_addr_i;
    logic [BE_WIDTH-1:0]   dbg_be_i;
    logic [DATA_WIDTH-1:0] dbg_wdata_i;
    logic                  dbg_gnt_o;
    logic                  dbg_rvalid_o;
    logic [DATA_WIDTH-1:0] dbg_rdata_o;
    logic                  dbg_lock_i;
    logic                  dbg_locked_o;

    logic                  ram_en_o;
    logic [BE_WIDTH-1:0]   ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_be_i, core_wdata_i,
        output core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_be_i, dbg_wdata_i, dbg_lock_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_locked_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_be_i, core_wdata_i,
        input  core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_be_i, dbg_wdata_i, dbg_lock_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_locked_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the core load/store path
// and the debug/loader unit, with same-cycle grant, one-deep read return and debug lock.
module data_ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    data_ram_arbiter_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {ST_ARB, ST_LOCK} state_t;
    typedef enum logic {OWN_CORE, OWN_DBG} owner_t;

    state_t                r_state;
    state_t                w_stateNext;
    owner_t                r_lastGrant;
    owner_t                w_lastGrantNext;
    logic                  r_rdPending;
    owner_t                r_rdOwner;

    logic                  w_coreGnt;
    logic                  w_dbgGnt;
    logic                  w_issueRead;
    logic                  w_ramEn;
    logic [BE_WIDTH-1:0]   w_ramWe;
    logic [ADDR_WIDTH-1:0] w_ramAddr;
    logic [DATA_WIDTH-1:0] w_ramWdata;
    logic                  w_coreRvalid;
    logic                  w_dbgRvalid;

    // Grant decision and next state; nothing is issued to the RAM while reset is held.
    always_comb begin
        w_coreGnt       = 1'b0;
        w_dbgGnt        = 1'b0;
        w_stateNext     = r_state;
        w_lastGrantNext = r_lastGrant;

        case (r_state)
            ST_ARB: begin
                if (bus.core_req_i && bus.dbg_req_i) begin
                    w_coreGnt = (r_lastGrant == OWN_DBG);
                    w_dbgGnt  = (r_lastGrant == OWN_CORE);
                end else begin
                    w_coreGnt = bus.core_req_i;
                    w_dbgGnt  = bus.dbg_req_i;
                end
                if (bus.dbg_lock_i) begin
                    w_stateNext = ST_LOCK;
                end
            end
            ST_LOCK: begin
                w_dbgGnt = bus.dbg_req_i;
                if (!bus.dbg_lock_i) begin
                    w_stateNext = ST_ARB;
                end
            end
            default: begin
                w_stateNext = ST_ARB;
            end
        endcase

        if (rst_i) begin
            w_coreGnt = 1'b0;
            w_dbgGnt  = 1'b0;
        end

        if (w_coreGnt) begin
            w_lastGrantNext = OWN_CORE;
        end else if (w_dbgGnt) begin
            w_lastGrantNext = OWN_DBG;
        end

        // Leaving lock always hands the first contended slot back to the core.
        if (r_state == ST_LOCK && !bus.dbg_lock_i) begin
            w_lastGrantNext = OWN_DBG;
        end
    end

    assign w_issueRead = (w_coreGnt && !bus.core_we_i) || (w_dbgGnt && !bus.dbg_we_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_ARB;
            r_lastGrant <= OWN_DBG;
            r_rdPending <= 1'b0;
            r_rdOwner   <= OWN_CORE;
        end else begin
            r_state     <= w_stateNext;
            r_lastGrant <= w_lastGrantNext;
            r_rdPending <= w_issueRead;
            r_rdOwner   <= w_dbgGnt ? OWN_DBG : OWN_CORE;
        end
    end

    always_comb begin
        w_ramEn    = 1'b0;
        w_ramWe    = '0;
        w_ramAddr  = '0;
        w_ramWdata = '0;
        if (w_coreGnt) begin
            w_ramEn    = 1'b1;
            w_ramWe    = bus.core_we_i ? bus.core_be_i : '0;
            w_ramAddr  = bus.core_addr_i;
            w_ramWdata = bus.core_wdata_i;
        end else if (w_dbgGnt) begin
            w_ramEn    = 1'b1;
            w_ramWe    = bus.dbg_we_i ? bus.dbg_be_i : '0;
            w_ramAddr  = bus.dbg_addr_i;
            w_ramWdata = bus.dbg_wdata_i;
        end
    end

    // A reset landing on the return cycle suppresses the pending read's rvalid.
    assign w_coreRvalid = r_rdPending && (r_rdOwner == OWN_CORE) && !rst_i;
    assign w_dbgRvalid  = r_rdPending && (r_rdOwner == OWN_DBG) && !rst_i;

    assign bus.core_gnt_o    = w_coreGnt;
    assign bus.core_stall_o  = bus.core_req_i && !w_coreGnt;
    assign bus.core_rvalid_o = w_coreRvalid;
    assign bus.core_rdata_o  = w_coreRvalid ? bus.ram_rdata_i : '0;

    assign bus.dbg_gnt_o     = w_dbgGnt;
    assign bus.dbg_rvalid_o  = w_dbgRvalid;
    assign bus.dbg_rdata_o   = w_dbgRvalid ? bus.ram_rdata_i : '0;
    assign bus.dbg_locked_o  = (r_state == ST_LOCK);

    assign bus.ram_en_o      = w_ramEn;
    assign bus.ram_we_o      = w_ramWe;
    assign bus.ram_addr_o    = w_ramAddr;
    assign bus.ram_wdata_o   = w_ramWdata;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed and random bench for data_ram_arbiter: a behavioural RAM macro plus a
// transaction-level model of arbitration, lock and read return.
module tb_data_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk_i = 1'b0;
    logic rst_i;

    data_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    data_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] initWord(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural single-port RAM macro with one-cycle read latency.
    logic [31:0] ramMem [0:1023];
    logic        ramLoaded = 1'b0;
    always @(posedge clk_i) begin
        if (!ramLoaded) begin
            for (int i = 0; i < 1024; i++) ramMem[i] <= initWord(i);
            ramLoaded <= 1'b1;
        end else if (bus.ram_en_o) begin
            if (bus.ram_we_o == 4'b0000) begin
                bus.ram_rdata_i <= ramMem[bus.ram_addr_o];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_we_o[b]) ramMem[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
            end
        end
    end

    // Reference model: memory image, lock flag, who wins the next tie, pending read.
    logic [31:0] refMem [0:1023];
    bit          mLocked, mCoreFirst, mPendValid, mPendCore;
    logic [31:0] mPendData;
    bit          eGntC, eGntD;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkCycle();
        bit          rvC, rvD, we;
        logic [3:0]  eWe;
        logic [9:0]  eAddr;
        logic [31:0] eWdata;
        eGntC = 0;
        eGntD = 0;
        if (!rst_i) begin
            if (mLocked) eGntD = bus.dbg_req_i;
            else if (bus.core_req_i && bus.dbg_req_i) begin
                eGntC = mCoreFirst;
                eGntD = !mCoreFirst;
            end else begin
                eGntC = bus.core_req_i;
                eGntD = bus.dbg_req_i;
            end
        end
        eWe = 4'b0; eAddr = '0; eWdata = '0;
        if (eGntC) begin
            we = bus.core_we_i; eAddr = bus.core_addr_i; eWdata = bus.core_wdata_i;
            eWe = we ? bus.core_be_i : 4'b0;
        end else if (eGntD) begin
            we = bus.dbg_we_i; eAddr = bus.dbg_addr_i; eWdata = bus.dbg_wdata_i;
            eWe = we ? bus.dbg_be_i : 4'b0;
        end
        rvC = mPendValid && mPendCore && !rst_i;
        rvD = mPendValid && !mPendCore && !rst_i;
        checkOutput("core_gnt", 32'(bus.core_gnt_o), 32'(eGntC));
        checkOutput("dbg_gnt", 32'(bus.dbg_gnt_o), 32'(eGntD));
        checkOutput("core_stall", 32'(bus.core_stall_o), 32'(bus.core_req_i && !eGntC));
        checkOutput("ram_en", 32'(bus.ram_en_o), 32'(eGntC || eGntD));
        checkOutput("ram_we", 32'(bus.ram_we_o), 32'(eWe));
        checkOutput("ram_addr", 32'(bus.ram_addr_o), 32'(eAddr));
        checkOutput("ram_wdata", bus.ram_wdata_o, eWdata);
        checkOutput("core_rvalid", 32'(bus.core_rvalid_o), 32'(rvC));
        checkOutput("core_rdata", bus.core_rdata_o, rvC ? mPendData : 32'h0);
        checkOutput("dbg_rvalid", 32'(bus.dbg_rvalid_o), 32'(rvD));
        checkOutput("dbg_rdata", bus.dbg_rdata_o, rvD ? mPendData : 32'h0);
        checkOutput("dbg_locked", 32'(bus.dbg_locked_o), 32'(mLocked));
    endtask

    task automatic updateModel();
        bit          we;
        logic [3:0]  be;
        logic [9:0]  addr;
        logic [31:0] wd, word;
        if (rst_i) begin
            mLocked = 0; mCoreFirst = 1; mPendValid = 0;
            return;
        end
        mPendValid = 0;
        if (eGntC || eGntD) begin
            we   = eGntC ? bus.core_we_i : bus.dbg_we_i;
            be   = eGntC ? bus.core_be_i : bus.dbg_be_i;
            addr = eGntC ? bus.core_addr_i : bus.dbg_addr_i;
            wd   = eGntC ? bus.core_wdata_i : bus.dbg_wdata_i;
            if (!we) begin
                mPendValid = 1; mPendCore = eGntC; mPendData = refMem[addr];
            end else begin
                word = refMem[addr];
                for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
                refMem[addr] = word;
            end
            mCoreFirst = eGntD;
        end
        if (mLocked && !bus.dbg_lock_i) begin
            mLocked = 0; mCoreFirst = 1;
        end else if (!mLocked && bus.dbg_lock_i) begin
            mLocked = 1;
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic applyStimulus(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            checkCycle();
            @(posedge clk_i);
            updateModel();
            #1;
        end
    endtask

    task automatic driveCore(input bit req, input bit we, input logic [9:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
        bus.core_req_i = req; bus.core_we_i = we; bus.core_addr_i = addr;
        bus.core_be_i = be; bus.core_wdata_i = wd;
    endtask

    task automatic driveDbg(input bit req, input bit we, input logic [9:0] addr,
                            input logic [3:0] be, input logic [31:0] wd);
        bus.dbg_req_i = req; bus.dbg_we_i = we; bus.dbg_addr_i = addr;
        bus.dbg_be_i = be; bus.dbg_wdata_i = wd;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);
        mLocked = 0; mCoreFirst = 1; mPendValid = 0; mPendCore = 0; mPendData = '0;
        rst_i = 1'b1;
        driveCore(0, 0, '0, '0, '0);
        driveDbg(0, 0, '0, '0, '0);
        bus.dbg_lock_i = 1'b0;
        applyStimulus(2);
        rst_i = 1'b0;

        $display("[TB] lone core read of 0x004");
        driveCore(1, 0, 10'h004, 4'h0, 32'h0);
        applyStimulus();
        driveCore(0, 0, '0, '0, '0);
        applyStimulus();

        $display("[TB] contention: core reads 0x010, debug writes 0x020");
        rst_i = 1'b1;
        applyStimulus();
        rst_i = 1'b0;
        driveCore(1, 0, 10'h010, 4'h0, 32'h0);
        driveDbg(1, 1, 10'h020, 4'hF, 32'h12345678);
        applyStimulus(4);
        driveCore(0, 0, '0, '0, '0);
        driveDbg(1, 0, 10'h020, 4'h0, 32'h0);
        applyStimulus();
        driveDbg(0, 0, '0, '0, '0);
        applyStimulus();

        $display("[TB] byte store and empty-mask write");
        driveCore(1, 1, 10'h008, 4'b0100, 32'h00AB0000);
        applyStimulus();
        driveCore(1, 0, 10'h008, 4'h0, 32'h0);
        driveDbg(1, 1, 10'h005, 4'b0000, 32'hFFFFFFFF);
        applyStimulus(3);
        driveCore(0, 0, '0, '0, '0);
        driveDbg(1, 0, 10'h005, 4'h0, 32'h0);
        applyStimulus();
        driveDbg(0, 0, '0, '0, '0);
        applyStimulus();

        $display("[TB] lock raised with a core read in flight");
        driveCore(1, 0, 10'h004, 4'h0, 32'h0);
        bus.dbg_lock_i = 1'b1;
        applyStimulus();
        driveDbg(1, 0, 10'h030, 4'h0, 32'h0);
        applyStimulus(4);
        bus.dbg_lock_i = 1'b0;
        applyStimulus(3);
        driveCore(0, 0, '0, '0, '0);
        driveDbg(0, 0, '0, '0, '0);
        applyStimulus();

        $display("[TB] reset right after a debug read grant");
        driveDbg(1, 0, 10'h030, 4'h0, 32'h0);
        bus.dbg_lock_i = 1'b1;
        applyStimulus();
        driveDbg(0, 0, '0, '0, '0);
        bus.dbg_lock_i = 1'b0;
        rst_i = 1'b1;
        applyStimulus();
        rst_i = 1'b0;
        applyStimulus(2);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            if (!bus.core_req_i || eGntC)
                driveCore(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                          10'($urandom_range(0, 15)), 4'($urandom), $urandom);
            if (!bus.dbg_req_i || eGntD)
                driveDbg(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                         10'($urandom_range(0, 15)), 4'($urandom), $urandom);
            if ($urandom_range(0, 15) == 0) bus.dbg_lock_i = ~bus.dbg_lock_i;
            rst_i = ($urandom_range(0, 99) == 0);
            applyStimulus();
        end
        rst_i = 1'b0;
        driveCore(0, 0, '0, '0, '0);
        driveDbg(0, 0, '0, '0, '0);
        bus.dbg_lock_i = 1'b0;
        applyStimulus(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU core's load/store path and the debug/loader unit.
- Sits between the data memory interface (which supplies the byte-enable mask and aligned write data) and the RAM macro.
- Performs round-robin arbitration with same-cycle grant and tracks the one-cycle read return.
- Provides an exclusive debug lock mode and a core stall indication.

Parameters:
- ADDR_WIDTH, 10, word-address width presented to the RAM.
- DATA_WIDTH, 32, data width; the byte-enable width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- core_req_i  in  1  core access request; held until granted.
- core_we_i  in  1  1 = store, 0 = load.
- core_addr_i  in  ADDR_WIDTH  word address.
- core_be_i  in  4  byte-enable mask for stores.
- core_wdata_i  in  32  aligned store data.
- core_gnt_o  out  1  access issued to RAM this cycle.
- core_stall_o  out  1  core_req_i & ~core_gnt_o.
- core_rvalid_o  out  1  load data valid (one cycle after a read grant).
- core_rdata_o  out  32  load data; 0 when core_rvalid_o=0.
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_be_i, dbg_wdata_i  in  1/1/ADDR_WIDTH/4/32  same meanings as the core_* inputs, for the debug port.
- dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o  out  1/1/32  same meanings as the core_* outputs, for the debug port.
- dbg_lock_i  in  1  request exclusive RAM ownership for debug.
- dbg_locked_o  out  1  lock mode active.
- ram_en_o  out  1  RAM access strobe.
- ram_we_o  out  4  per-byte write strobes; 0 for reads.
- ram_addr_o  out  ADDR_WIDTH  RAM word address.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_en_o with ram_we_o=0.

Behaviour:
- Reset is synchronous, active-high. On reset:
  - state=ARB; last_grant=DBG, so the core wins the first contention.
  - In-flight read tag cleared.
  - core_rvalid_o=dbg_rvalid_o=0, dbg_locked_o=0.
  - Grant and RAM outputs are combinational and therefore 0 while no request is present.
- A reset asserted while a read is in flight discards that read: no rvalid follows.
- Grants are combinational in the same cycle as the request, with at most one grant per cycle.
  - A granted write commits at the clock edge of the grant cycle.
  - A granted read returns data on the next cycle with the matching rvalid=1 for exactly one cycle.
- Back-to-back grants every cycle are allowed: the read pipeline depth is 1, with no bubbles.
- RAM mux, driven from the granted port:
  - ram_en_o=1.
  - ram_we_o = we ? be : 4'b0000.
  - ram_addr_o and ram_wdata_o taken from the granted port.
  - With no grant, all RAM outputs are 0.
- A write with be=0000 is still granted and issued; it has no memory effect and produces no rvalid.
- State machine, ARB state (dbg_locked_o=0):
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not in last_grant is granted.
  - last_grant updates on every grant.
  - dbg_lock_i=1 moves to LOCK at the next edge.
- State machine, LOCK state (dbg_locked_o=1):
  - core_gnt_o=0 and core_stall_o follows core_req_i.
  - The debug port is granted whenever dbg_req_i=1.
  - dbg_lock_i=0 returns to ARB at the next edge; last_grant is forced to DBG.
- A core read granted in the cycle lock is asserted still returns its core_rvalid_o on the next cycle.
- The rvalid tag records the port owner of the read issued in cycle N and selects which rvalid/rdata fires in cycle N+1.
- Requesters must hold req, we, addr, be and wdata stable until granted. The arbiter does not register the request, so a dropped request is simply never served.
- The debug port is never locked out in ARB; the core is never starved in ARB, since each port wins at least every second contended cycle.

Test Plan:
- Reset, then core read of addr 0x004 alone, RAM returns 0xDEADBEEF:
  - core_gnt_o=1 in cycle 0 with ram_en_o=1, ram_we_o=0000, ram_addr_o=0x004.
  - core_rvalid_o=1 and core_rdata_o=0xDEADBEEF in cycle 1; dbg_rvalid_o=0.
- Both ports request continuously for 4 cycles, core reading 0x010 and debug writing 0x020 with be=1111:
  - Grants go core, dbg, core, dbg.
  - core_rvalid_o pulses in cycles 1 and 3.
  - core_stall_o=1 in cycles 1 and 3.
- Core store to 0x008 with be=0100 and wdata=0x00AB0000 while debug is idle:
  - ram_we_o=0100 and ram_wdata_o=0x00AB0000 in the grant cycle; no rvalid follows.
- Core read granted in cycle 0 with dbg_lock_i rising in cycle 0, core requesting continuously from cycle 1:
  - core_rvalid_o=1 in cycle 1.
  - dbg_locked_o=1 from cycle 1 onward, with core_gnt_o=0 and core_stall_o=1.
  - A debug read of 0x030 is granted every cycle.
- dbg_lock_i drops with both ports requesting:
  - The next cycle is ARB with core granted first.
- rst_i asserted in the cycle after a debug read grant:
  - dbg_rvalid_o=0 in that cycle and the next; state=ARB and dbg_locked_o=0 after reset.
